// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with single-step, halt and retire counter.
// Optional macro OVF_TRAP_EN: overflow in EXEC of an R/I instruction halts the core instead of writing back.
module multicycle_control_unit #(
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter logic [3:0] ALU_ADD     = 4'h0,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero_flag,
  input  logic             negative_flag,
  input  logic             overflow_flag,
  output logic             updPc,
  output logic             reg_dst,
  output logic             wr_reg,
  output logic [3:0]       alu_control,
  output logic             alu_src,
  output logic             immSel,
  output logic             rdMem,
  output logic             wrMem,
  output logic             mToReg,
  output logic [2:0]       brOp,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {K_R, K_I, K_LD, K_ST, K_BR, K_ILL, K_HALT} kind_t;

  state_t           r_state, w_state_next;
  kind_t            r_kind, w_kind;
  logic             r_reg_dst, w_reg_dst;
  logic [3:0]       r_alu_control, w_alu_control;
  logic             r_alu_src, w_alu_src;
  logic             r_imm_sel, w_imm_sel;
  logic             r_m_to_reg, w_m_to_reg;
  logic [2:0]       r_br_op, w_br_op;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  logic             w_held;
  logic             w_unused_flags;

  // Flags feed branch resolution in the datapath; only overflow may matter here.
  assign w_unused_flags = ^{zero_flag, negative_flag, overflow_flag};

  // Instruction decode; illegal encodings leave every control field at 0 so they run as a NOP.
  always_comb begin
    w_kind        = K_ILL;
    w_reg_dst     = 1'b0;
    w_alu_control = 4'h0;
    w_alu_src     = 1'b0;
    w_imm_sel     = 1'b0;
    w_m_to_reg    = 1'b0;
    w_br_op       = 3'b000;
    if (opcode == HALT_OPCODE) begin
      w_kind = K_HALT;
    end else begin
      case (opcode[5:4])
        2'b00: begin
          if (funct[5:4] == 2'b00) begin
            w_kind        = K_R;
            w_alu_control = funct[3:0];
            w_reg_dst     = 1'b1;
            w_alu_src     = 1'b1;
          end
        end
        2'b01: begin
          w_kind        = K_I;
          w_alu_control = opcode[3:0];
        end
        2'b10: begin
          if (opcode[3:0] == 4'h0) begin
            w_kind        = K_LD;
            w_alu_control = ALU_ADD;
            w_m_to_reg    = 1'b1;
          end else if (opcode[3:0] == 4'h1) begin
            w_kind        = K_ST;
            w_alu_control = ALU_ADD;
          end
        end
        default: begin
          w_kind        = K_BR;
          w_br_op       = opcode[2:0];
          w_imm_sel     = (opcode[2:0] == 3'b001);
          w_alu_control = ALU_ADD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  if (run) w_state_next = S_DECODE;
      S_DECODE: w_state_next = (w_kind == K_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (r_kind)
          K_R, K_I: begin
`ifdef OVF_TRAP_EN
            w_state_next = overflow_flag ? S_HALT : S_WB;
`else
            w_state_next = S_WB;
`endif
          end
          K_LD, K_ST: w_state_next = S_MEM;
          default:    w_state_next = S_FETCH;
        endcase
      end
      S_MEM:   w_state_next = (r_kind == K_LD) ? S_WB : S_FETCH;
      S_WB:    w_state_next = S_FETCH;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_FETCH;
    endcase
  end

  // Decode is captured once, on leaving DECODE, so it stays stable for the rest of the instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kind        <= K_R;
      r_reg_dst     <= 1'b0;
      r_alu_control <= 4'h0;
      r_alu_src     <= 1'b0;
      r_imm_sel     <= 1'b0;
      r_m_to_reg    <= 1'b0;
      r_br_op       <= 3'b000;
      r_illegal     <= 1'b0;
      r_retired     <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_kind        <= w_kind;
        r_reg_dst     <= w_reg_dst;
        r_alu_control <= w_alu_control;
        r_alu_src     <= w_alu_src;
        r_imm_sel     <= w_imm_sel;
        r_m_to_reg    <= w_m_to_reg;
        r_br_op       <= w_br_op;
        if (w_kind == K_ILL) r_illegal <= 1'b1;
      end
      if (updPc) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign w_held = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

  always_comb begin
    updPc       = 1'b0;
    wr_reg      = 1'b0;
    rdMem       = 1'b0;
    wrMem       = 1'b0;
    brOp        = 3'b000;
    halted      = 1'b0;
    reg_dst     = w_held ? r_reg_dst     : 1'b0;
    alu_control = w_held ? r_alu_control : 4'h0;
    alu_src     = w_held ? r_alu_src     : 1'b0;
    immSel      = w_held ? r_imm_sel     : 1'b0;
    mToReg      = w_held ? r_m_to_reg    : 1'b0;
    case (r_state)
      S_EXEC: begin
        brOp  = r_br_op;
        updPc = (r_kind == K_BR) || (r_kind == K_ILL);
      end
      S_MEM: begin
        rdMem = (r_kind == K_LD);
        wrMem = (r_kind == K_ST);
        updPc = (r_kind == K_ST);
      end
      S_WB: begin
        wr_reg = 1'b1;
        rdMem  = (r_kind == K_LD);
        updPc  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected output trace model plus directed literal checks.
module tb_multicycle_control_unit;

  localparam int TB_W = 8;
`ifdef OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, run, zero_flag, negative_flag, overflow_flag;
  logic [5:0]      opcode, funct;
  logic            updPc, reg_dst, wr_reg, alu_src, immSel, rdMem, wrMem, mToReg, halted, illegal;
  logic [3:0]      alu_control;
  logic [2:0]      brOp, state;
  logic [TB_W-1:0] retired;

  multicycle_control_unit #(.CNT_W(TB_W)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .negative_flag(negative_flag), .overflow_flag(overflow_flag),
    .updPc(updPc), .reg_dst(reg_dst), .wr_reg(wr_reg), .alu_control(alu_control),
    .alu_src(alu_src), .immSel(immSel), .rdMem(rdMem), .wrMem(wrMem), .mToReg(mToReg),
    .brOp(brOp), .halted(halted), .illegal(illegal), .state(state), .retired(retired)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       upd;
    logic       rdst;
    logic       wr;
    logic [3:0] alu;
    logic       asrc;
    logic       imm;
    logic       rd;
    logic       wm;
    logic       m2r;
    logic [2:0] br;
    logic       hlt;
  } out_t;

  typedef struct packed {
    out_t o;
    logic ill;
  } vec_t;

  vec_t            q[$];
  vec_t            cur;
  logic [TB_W-1:0] m_ret;
  logic            m_ill, m_halted;
  bit              chk_en = 1'b0;
  int              n_checks = 0;
  int              n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] st);
    vec_t v;
    v = '0;
    v.o.st  = st;
    v.o.hlt = (st == 3'd5);
    return v;
  endfunction

  // Expected per-cycle outputs of one instruction, from DECODE to its last state.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    vec_t e, v;
    int   cls;  // 0 R, 1 I, 2 LD, 3 ST, 4 branch, 5 illegal
    q.push_back(mk(3'd1));
    if (op == 6'h3F) begin
      q.push_back(mk(3'd5));
      return;
    end
    e = mk(3'd2);
    case (op[5:4])
      2'd0: begin
        cls = (fn[5:4] == 2'd0) ? 0 : 5;
        if (cls == 0) begin e.o.alu = fn[3:0]; e.o.rdst = 1'b1; e.o.asrc = 1'b1; end
      end
      2'd1: begin cls = 1; e.o.alu = op[3:0]; end
      2'd2: begin
        cls = (op[3:0] == 4'd0) ? 2 : (op[3:0] == 4'd1) ? 3 : 5;
        if (cls == 2) e.o.m2r = 1'b1;
      end
      default: begin cls = 4; e.o.br = op[2:0]; e.o.imm = (op[2:0] == 3'd1); end
    endcase
    if (cls >= 4) begin
      e.ill   = (cls == 5);
      e.o.upd = 1'b1;
      q.push_back(e);
      return;
    end
    q.push_back(e);
    v = e;
    v.o.br = 3'd0;
    if (cls <= 1) begin
      if (TRAP && ovf) q.push_back(mk(3'd5));
      else begin v.o.st = 3'd4; v.o.wr = 1'b1; v.o.upd = 1'b1; q.push_back(v); end
    end else if (cls == 2) begin
      v.o.st = 3'd3; v.o.rd = 1'b1; q.push_back(v);
      v.o.st = 3'd4; v.o.wr = 1'b1; v.o.upd = 1'b1; q.push_back(v);
    end else begin
      v.o.st = 3'd3; v.o.wm = 1'b1; v.o.upd = 1'b1; q.push_back(v);
    end
  endtask

  // Model: advances one cycle per clock edge using the inputs the DUT samples at that edge.
  initial begin
    cur = mk(3'd0); m_ret = '0; m_ill = 1'b0; m_halted = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        cur = mk(3'd0); m_ret = '0; m_ill = 1'b0; m_halted = 1'b0;
      end else begin
        if (cur.o.upd) m_ret = m_ret + 8'd1;
        if (m_halted) cur = mk(3'd5);
        else if (q.size() > 0) cur = q.pop_front();
        else if (cur.o.st == 3'd0 && run) begin
          build(opcode, funct, overflow_flag);
          cur = q.pop_front();
        end else cur = mk(3'd0);
        if (cur.ill) m_ill = 1'b1;
        if (cur.o.hlt) m_halted = 1'b1;
      end
    end
  end

  // Compare every cycle against the model.
  initial begin
    out_t act;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        act = {state, updPc, reg_dst, wr_reg, alu_control, alu_src, immSel,
               rdMem, wrMem, mToReg, brOp, halted};
        chk("outputs", {13'd0, act}, {13'd0, cur.o});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
        chk("retired", {24'd0, retired}, {24'd0, m_ret});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse run for one FETCH cycle and trace the instruction until FETCH or HALT.
  task automatic run_one(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                         input int e_cyc, input logic [23:0] e_st, input int e_npc, input int e_nwr);
    int          cyc, npc, nwr;
    logic [23:0] st;
    bit          ok;
    opcode = op; funct = fn; overflow_flag = ovf; run = 1'b1;
    cyc = 0; npc = 0; nwr = 0; st = '0; ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      st = {st[20:0], state};
      cyc++;
      if (updPc) npc++;
      if (wr_reg) nwr++;
      tick();
      run = 1'b0;
      if (state == 3'd0 || state == 3'd5) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: got no FETCH/HALT return, required one within 8 cycles", nm);
    end
    chk({nm, "_cycles"}, 32'(cyc), 32'(e_cyc));
    chk({nm, "_states"}, {8'd0, st}, {8'd0, e_st});
    chk({nm, "_updpc"}, 32'(npc), 32'(e_npc));
    chk({nm, "_wrreg"}, 32'(nwr), 32'(e_nwr));
  endtask

  initial begin
    bit found;
    reset = 1'b1; run = 1'b0; opcode = '0; funct = '0;
    zero_flag = 1'b0; negative_flag = 1'b0; overflow_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", {24'd0, retired}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    tick();

    run_one("add", 6'h00, 6'h00, 1'b0, 4, 24'o0124, 1, 1);
    chk("add_retired", {24'd0, retired}, 32'd1);
    run_one("ld", 6'h20, 6'h00, 1'b0, 5, 24'o01234, 1, 1);
    run_one("st", 6'h21, 6'h00, 1'b0, 4, 24'o0123, 1, 0);
    zero_flag = 1'b1; negative_flag = 1'b1;
    run_one("br", 6'h31, 6'h00, 1'b0, 3, 24'o012, 1, 0);
    zero_flag = 1'b0; negative_flag = 1'b0;
    run_one("itype", 6'h15, 6'h00, 1'b0, 4, 24'o0124, 1, 1);
    chk("seq_retired", {24'd0, retired}, 32'd5);

    repeat (10) tick();
    chk("pause_state", 32'(state), 32'd0);
    chk("pause_retired", {24'd0, retired}, 32'd5);
    run_one("step", 6'h00, 6'h02, 1'b0, 4, 24'o0124, 1, 1);
    chk("step_retired", {24'd0, retired}, 32'd6);

    run_one("ill_r", 6'h00, 6'h30, 1'b0, 3, 24'o012, 1, 0);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    run_one("ill_mem", 6'h25, 6'h00, 1'b0, 3, 24'o012, 1, 0);
    chk("ill_retired", {24'd0, retired}, 32'd8);

    for (int i = 0; i < 250; i++)
      run_one("br_loop", {3'b110, i[2:0]}, 6'h00, 1'b0, 3, 24'o012, 1, 0);
    chk("wrap_retired", {24'd0, retired}, 32'd2);
    chk("ill_sticky", {31'd0, illegal}, 32'd1);

    opcode = 6'h20; funct = 6'h00; run = 1'b1;
    tick();
    run = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (state == 3'd3) begin found = 1'b1; break; end
      tick();
    end
    if (!found) begin
      n_checks++; n_err++;
      $display("FAIL ld_mem_wait: got state %0d, required 3 within 6 cycles", state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_retired", {24'd0, retired}, 32'd0);
    chk("midrst_illegal", {31'd0, illegal}, 32'd0);
    chk("midrst_rdmem", {31'd0, rdMem}, 32'd0);
    tick();

    run_one("add2", 6'h00, 6'h00, 1'b0, 4, 24'o0124, 1, 1);
    run_one("halt", 6'h3F, 6'h00, 1'b0, 2, 24'o01, 0, 0);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    run = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    chk("halt_stays", 32'(state), 32'd5);
    chk("halt_retired", {24'd0, retired}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("unhalt_state", 32'(state), 32'd0);
    chk("unhalt_halted", {31'd0, halted}, 32'd0);
    tick();

`ifdef OVF_TRAP_EN
    run_one("ovf", 6'h00, 6'h00, 1'b1, 3, 24'o012, 0, 0);
    chk("ovf_halted", {31'd0, halted}, 32'd1);
    chk("ovf_retired", {24'd0, retired}, 32'd0);
`else
    run_one("ovf", 6'h00, 6'h00, 1'b1, 4, 24'o0124, 1, 1);
    chk("ovf_retired", {24'd0, retired}, 32'd1);
`endif
    overflow_flag = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
